// File: rtl/wb_arbiter.sv
// Collects FU results into an in-order circular buffer and drains up to N per cycle onto PRF_WRITE.
// Latency: a result accepted at edge t is on prf_write during the next cycle; older entries go first.
// Backpressure: fu_ready[k] depends only on registered free space; the PRF side never stalls.
module wb_arbiter #(
  parameter int N      = 2,
  parameter int NUM_FU = 4,
  parameter int DEPTH  = 8,
  parameter int PRN_W  = 6,
  parameter int DATA_W = 32
) (
  input  logic                                 clock,
  input  logic                                 reset,
  input  logic [NUM_FU-1:0]                    fu_valid,
  input  logic [NUM_FU-1:0][PRN_W-1:0]         fu_prn,
  input  logic [NUM_FU-1:0][DATA_W-1:0]        fu_value,
  output logic [NUM_FU-1:0]                    fu_ready,
  input  logic                                 squash,
  output logic [N-1:0][DATA_W+PRN_W-1:0]       prf_write,
  output logic [$clog2(DEPTH):0]               count
);

  localparam int PTR_W = $clog2(DEPTH);
  localparam int CNT_W = PTR_W + 1;

  // One buffered result; layout matches a PRF_WRITE slot {value, prn}.
  typedef struct packed {
    logic [DATA_W-1:0] value;
    logic [PRN_W-1:0]  prn;
  } entry_t;

  entry_t             mem [DEPTH];
  logic [PTR_W-1:0]   head;
  logic [PTR_W-1:0]   tail;
  logic [CNT_W-1:0]   free_slots;
  logic [CNT_W-1:0]   n_pop;
  logic [CNT_W-1:0]   n_push;
  logic [NUM_FU-1:0]  wr_en;
  logic [PTR_W-1:0]   wr_idx [NUM_FU];

  // Ready from registered occupancy only, so no path from fu_valid or pops back to fu_ready.
  always_comb begin
    free_slots = CNT_W'(DEPTH) - count;
    for (int k = 0; k < NUM_FU; k++) begin
      fu_ready[k] = (CNT_W'(k) < free_slots);
    end
  end

  // Drain the oldest min(N, count) entries; unused slots read prn=0 (no write).
  always_comb begin
    n_pop = (count < CNT_W'(N)) ? count : CNT_W'(N);
    for (int i = 0; i < N; i++) begin
      prf_write[i] = '0;
      if (CNT_W'(i) < n_pop) begin
        prf_write[i] = mem[head + PTR_W'(i)];
      end
    end
  end

  // Compact accepted, non-zero-PRN results onto the tail in ascending FU order.
  always_comb begin
    n_push = '0;
    for (int k = 0; k < NUM_FU; k++) begin
      wr_en[k]  = fu_valid[k] && fu_ready[k] && (fu_prn[k] != '0);
      wr_idx[k] = tail + n_push[PTR_W-1:0];
      if (wr_en[k]) begin
        n_push = n_push + CNT_W'(1);
      end
    end
  end

  // Pointer and occupancy update; reset and squash both empty the buffer and drop this cycle's handshakes.
  always_ff @(posedge clock) begin
    if (reset || squash) begin
      head  <= '0;
      tail  <= '0;
      count <= '0;
    end else begin
      head  <= head + n_pop[PTR_W-1:0];
      tail  <= tail + n_push[PTR_W-1:0];
      count <= count - n_pop + n_push;
    end
  end

  // Storage writes; contents need no reset since slots are gated by count.
  always_ff @(posedge clock) begin
    if (!reset && !squash) begin
      for (int k = 0; k < NUM_FU; k++) begin
        if (wr_en[k]) begin
          mem[wr_idx[k]] <= '{value: fu_value[k], prn: fu_prn[k]};
        end
      end
    end
  end

endmodule

// File: tb/tb_wb_arbiter.sv
// Randomised and directed stimulus for wb_arbiter, checked against an in-order queue model.
// Inputs change just after the rising edge; outputs are sampled on the falling edge.
// The model retires min(N, occupancy) results per cycle and accepts FU k while k < free space.
module tb_wb_arbiter;

  localparam int N      = 2;
  localparam int NUM_FU = 4;
  localparam int DEPTH  = 8;
  localparam int PRN_W  = 6;
  localparam int DATA_W = 32;
  localparam int SLOT_W = DATA_W + PRN_W;
  localparam int CNT_W  = $clog2(DEPTH) + 1;

  typedef logic [NUM_FU-1:0][PRN_W-1:0]  prn_vec_t;
  typedef logic [NUM_FU-1:0][DATA_W-1:0] val_vec_t;

  logic                          clock = 1'b0;
  logic                          reset;
  logic [NUM_FU-1:0]             fu_valid;
  prn_vec_t                      fu_prn;
  val_vec_t                      fu_value;
  logic [NUM_FU-1:0]             fu_ready;
  logic                          squash;
  logic [N-1:0][SLOT_W-1:0]      prf_write;
  logic [CNT_W-1:0]              count;

  int total = 0;
  int bad   = 0;

  // Reference: oldest result at the front, each entry {value, prn}.
  logic [SLOT_W-1:0] q[$];

  always #5 clock = ~clock;

  wb_arbiter #(
    .N(N), .NUM_FU(NUM_FU), .DEPTH(DEPTH), .PRN_W(PRN_W), .DATA_W(DATA_W)
  ) dut (
    .clock    (clock),
    .reset    (reset),
    .fu_valid (fu_valid),
    .fu_prn   (fu_prn),
    .fu_value (fu_value),
    .fu_ready (fu_ready),
    .squash   (squash),
    .prf_write(prf_write),
    .count    (count)
  );

  task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s got=%0h exp=%0h (t=%0t)", tag, got, exp, $time);
    end
  endtask

  // Drive one cycle of inputs, check outputs against the model, then advance the model across the edge.
  task automatic step(input logic rst, input logic sq, input logic [NUM_FU-1:0] vld,
                      input prn_vec_t prns, input val_vec_t vals);
    int                npop;
    logic [NUM_FU-1:0] exp_rdy;
    logic [SLOT_W-1:0] exp_slot;
    reset    = rst;
    squash   = sq;
    fu_valid = vld;
    fu_prn   = prns;
    fu_value = vals;
    @(negedge clock);
    for (int k = 0; k < NUM_FU; k++) exp_rdy[k] = (k < DEPTH - q.size());
    chk("count", 64'(count), 64'(q.size()));
    chk("fu_ready", 64'(fu_ready), 64'(exp_rdy));
    npop = (q.size() < N) ? q.size() : N;
    for (int i = 0; i < N; i++) begin
      exp_slot = (i < npop) ? q[i] : '0;
      chk($sformatf("slot%0d", i), 64'(prf_write[i]), 64'(exp_slot));
    end
    if (rst || sq) begin
      q.delete();
    end else begin
      for (int i = 0; i < npop; i++) void'(q.pop_front());
      for (int k = 0; k < NUM_FU; k++) begin
        if (vld[k] && exp_rdy[k] && prns[k] != '0) q.push_back({vals[k], prns[k]});
      end
    end
    @(posedge clock);
    #1;
  endtask

  task automatic idle(input int cycles);
    for (int c = 0; c < cycles; c++) step(1'b0, 1'b0, '0, '0, '0);
  endtask

  initial begin
    prn_vec_t          p;
    val_vec_t          v;
    logic [NUM_FU-1:0] vld;
    logic              sq;
    logic              rst;

    reset    = 1'b1;
    squash   = 1'b0;
    fu_valid = '0;
    fu_prn   = '0;
    fu_value = '0;
    repeat (2) @(posedge clock);
    #1;

    // Reset state, then a single result.
    idle(1);
    p = '0; v = '0;
    p[0] = 6'd5; v[0] = 32'hAA;
    step(1'b0, 1'b0, 4'b0001, p, v);
    idle(2);

    // Burst of four, drained two per cycle in FU order.
    for (int k = 0; k < NUM_FU; k++) begin
      p[k] = PRN_W'(10 + k);
      v[k] = 32'h100 + 32'(k);
    end
    step(1'b0, 1'b0, 4'b1111, p, v);
    idle(3);

    // Sustained pressure: all FUs valid for several cycles.
    for (int c = 0; c < 6; c++) begin
      for (int k = 0; k < NUM_FU; k++) begin
        p[k] = PRN_W'(1 + ((c * NUM_FU + k) % 63));
        v[k] = 32'h2000 + 32'(c * NUM_FU + k);
      end
      step(1'b0, 1'b0, 4'b1111, p, v);
    end
    idle(5);

    // Twenty sequential singles with prns 1..20 across the pointer wrap.
    for (int j = 1; j <= 20; j++) begin
      p = '0; v = '0;
      p[j % NUM_FU] = PRN_W'(j);
      v[j % NUM_FU] = 32'h3000 + 32'(j);
      step(1'b0, 1'b0, 4'(1 << (j % NUM_FU)), p, v);
    end
    idle(2);

    // Zero-PRN result is consumed but never written.
    p = '0; v = '0;
    p[0] = 6'd0; v[0] = 32'hDEAD;
    p[1] = 6'd7; v[1] = 32'h77;
    step(1'b0, 1'b0, 4'b0011, p, v);
    idle(2);

    // Build occupancy 5, then squash with all FUs valid.
    for (int k = 0; k < NUM_FU; k++) begin
      p[k] = PRN_W'(20 + k);
      v[k] = 32'h4000 + 32'(k);
    end
    step(1'b0, 1'b0, 4'b1111, p, v);
    for (int k = 0; k < NUM_FU; k++) begin
      p[k] = PRN_W'(30 + k);
      v[k] = 32'h5000 + 32'(k);
    end
    step(1'b0, 1'b0, 4'b0111, p, v);
    step(1'b0, 1'b1, 4'b1111, p, v);
    idle(2);

    // Reset in the middle of traffic.
    step(1'b0, 1'b0, 4'b1111, p, v);
    step(1'b1, 1'b1, 4'b1111, p, v);
    idle(1);

    // Random traffic with occasional zero prns, squashes and resets.
    for (int c = 0; c < 1500; c++) begin
      vld = ($urandom_range(0, 3) == 0) ? 4'($urandom) : 4'b1111;
      for (int k = 0; k < NUM_FU; k++) begin
        p[k] = ($urandom_range(0, 7) == 0) ? '0 : PRN_W'($urandom_range(1, 63));
        v[k] = $urandom;
      end
      sq  = ($urandom_range(0, 39) == 0);
      rst = ($urandom_range(0, 249) == 0);
      step(rst, sq, vld, p, v);
    end
    idle(5);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
